piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 117 +++++++++++
 tb/tb_piso_serializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out converter with a one-word holding
// register, so that back-to-back frames stream with no idle gap. Each bit is
// held for DIV clocks, and frame_done marks the last cycle of every frame.
module piso_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             msb_first,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;      // always kept in transmit order, LSB goes out first
    logic [WIDTH-1:0] hold_word;
    logic             hold_msb;
    logic             hold_full;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;

    logic accept;
    logic bit_end;
    logic frame_end;

    // Reorder a captured word so that the shift register only ever shifts right.
    function automatic logic [WIDTH-1:0] tx_order(input logic [WIDTH-1:0] w,
                                                  input logic             msb);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = msb ? w[WIDTH-1-i] : w[i];
        end
        return r;
    endfunction

    assign load_ready = ~hold_full;
    assign accept     = load_valid & load_ready;
    assign bit_end    = (div_cnt == DIV_LAST);
    assign frame_end  = (state == SHIFT) && bit_end && (bit_cnt == BIT_LAST);

    assign ser_valid  = (state == SHIFT);
    assign ser_out    = (state == SHIFT) & shreg[0];
    assign frame_done = frame_end;

    // Shift engine: state, counters and shift register; reloads at frame end
    // from hold first, then from a same-edge accept, otherwise goes idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg   <= tx_order(data_in, msb_first);
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                default: begin
                    if (frame_end) begin
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        if (hold_full) begin
                            shreg <= tx_order(hold_word, hold_msb);
                        end else if (accept) begin
                            shreg <= tx_order(data_in, msb_first);
                        end else begin
                            shreg <= '0;
                            state <= IDLE;
                        end
                    end else if (bit_end) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= shreg >> 1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Holding register: fills on a mid-frame accept, drains at every frame end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_word <= '0;
            hold_msb  <= 1'b0;
        end else if (state == SHIFT) begin
            if (frame_end) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold_word <= data_in;
                hold_msb  <= msb_first;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: two instances (8 bits / DIV 1 and 4 bits / DIV 3) checked
// every cycle against a queue model of the expected serial stream, plus literal
// bit patterns for the directed scenarios.
module tb_piso_serializer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0] din_a = 8'h00;
    logic       msb_a = 1'b0;
    logic       lv_a  = 1'b0;
    logic       lr_a, so_a, sv_a, fd_a;

    logic [3:0] din_b = 4'h0;
    logic       msb_b = 1'b0;
    logic       lv_b  = 1'b0;
    logic       lr_b, so_b, sv_b, fd_b;

    piso_serializer #(.WIDTH(8), .DIV(1)) dut_a (
        .clock(clock), .reset(reset), .data_in(din_a), .msb_first(msb_a),
        .load_valid(lv_a), .load_ready(lr_a), .ser_out(so_a),
        .ser_valid(sv_a), .frame_done(fd_a)
    );

    piso_serializer #(.WIDTH(4), .DIV(3)) dut_b (
        .clock(clock), .reset(reset), .data_in(din_b), .msb_first(msb_b),
        .load_valid(lv_b), .load_ready(lr_b), .ser_out(so_b),
        .ser_valid(sv_b), .frame_done(fd_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: every accepted word appends its whole frame of output cycles
    // ({frame_done, ser_valid, ser_out}) to a queue; one entry plays per cycle.
    // The block can take a word whenever less than one full frame is still
    // queued behind the cycle currently shown.
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    logic [2:0] ea = 3'b000;
    logic [2:0] eb = 3'b000;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            qa.delete();
            qb.delete();
            ea = 3'b000;
            eb = 3'b000;
        end else begin
            if (lv_a && qa.size() < 8) begin
                for (int j = 0; j < 8; j++) begin
                    logic [7:0] t;
                    t = din_a >> (msb_a ? 7 - j : j);
                    qa.push_back({(j == 7), 1'b1, t[0]});
                end
            end
            if (lv_b && qb.size() < 12) begin
                for (int j = 0; j < 12; j++) begin
                    logic [3:0] t;
                    t = din_b >> (msb_b ? 3 - j / 3 : j / 3);
                    qb.push_back({(j == 11), 1'b1, t[0]});
                end
            end
            ea = (qa.size() != 0) ? qa.pop_front() : 3'b000;
            eb = (qb.size() != 0) ? qb.pop_front() : 3'b000;
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clock) begin
        check("a_out",   so_a, ea[0]);
        check("a_valid", sv_a, ea[1]);
        check("a_done",  fd_a, ea[2]);
        check("a_ready", lr_a, qa.size() < 8);
        check("b_out",   so_b, eb[0]);
        check("b_valid", sv_b, eb[1]);
        check("b_done",  fd_b, eb[2]);
        check("b_ready", lr_b, qb.size() < 12);
    end

    // Output history, newest sample in bit 0, for the literal pattern checks.
    logic [31:0] ca_o = '0, ca_v = '0, ca_f = '0;
    logic [31:0] cb_o = '0, cb_v = '0, cb_f = '0;
    always @(negedge clock) begin
        ca_o = {ca_o[30:0], so_a};
        ca_v = {ca_v[30:0], sv_a};
        ca_f = {ca_f[30:0], fd_a};
        cb_o = {cb_o[30:0], so_b};
        cb_v = {cb_v[30:0], sv_b};
        cb_f = {cb_f[30:0], fd_b};
    end

    function automatic logic [31:0] last(input logic [31:0] v, input int n);
        return v & ((32'd1 << n) - 32'd1);
    endfunction

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) tick();
        check("rst_ready", lr_a, 1'b1);
        check("rst_valid", sv_a, 1'b0);
        check("rst_out",   so_a, 1'b0);
        check("rst_done",  fd_a, 1'b0);
        reset = 1'b0;

        // B4 MSB-first, offered on the first edge after reset release.
        din_a = 8'hB4; msb_a = 1'b1; lv_a = 1'b1;
        tick(); lv_a = 1'b0;
        settle(9);
        check("t1_out",   last(ca_o, 10), 32'b0_10110100_0);
        check("t1_valid", last(ca_v, 10), 32'b0_11111111_0);
        check("t1_done",  last(ca_f, 10), 32'b0_00000001_0);

        // B4 LSB-first.
        tick();
        din_a = 8'hB4; msb_a = 1'b0; lv_a = 1'b1;
        tick(); lv_a = 1'b0;
        settle(9);
        check("t2_out",   last(ca_o, 10), 32'b0_00101101_0);
        check("t2_valid", last(ca_v, 10), 32'b0_11111111_0);

        // F0 then 0F queued in hold during the first frame.
        tick();
        din_a = 8'hF0; msb_a = 1'b1; lv_a = 1'b1;
        tick();
        din_a = 8'h0F;
        tick(); lv_a = 1'b0;
        check("t3_ready_low", lr_a, 1'b0);
        settle(16);
        check("t3_out",   last(ca_o, 18), 32'b0_11110000_00001111_0);
        check("t3_valid", last(ca_v, 18), 32'b0_11111111_11111111_0);
        check("t3_done",  last(ca_f, 18), 32'b0_00000001_00000001_0);

        // A5 offered only on the frame-end edge with hold empty.
        tick();
        din_a = 8'hF0; msb_a = 1'b1; lv_a = 1'b1;
        tick(); lv_a = 1'b0;
        repeat (7) tick();
        check("t4_ready_end", lr_a, 1'b1);
        check("t4_done_end",  fd_a, 1'b1);
        din_a = 8'hA5; lv_a = 1'b1;
        tick(); lv_a = 1'b0;
        settle(9);
        check("t4_out",   last(ca_o, 18), 32'b0_11110000_10100101_0);
        check("t4_valid", last(ca_v, 18), 32'b0_11111111_11111111_0);
        check("t4_done",  last(ca_f, 18), 32'b0_00000001_00000001_0);

        // 4-bit, DIV=3: 1001 MSB-first.
        tick();
        din_b = 4'b1001; msb_b = 1'b1; lv_b = 1'b1;
        tick(); lv_b = 1'b0;
        settle(13);
        check("t5_out",   last(cb_o, 14), 32'b0_111000000111_0);
        check("t5_valid", last(cb_v, 14), 32'b0_111111111111_0);
        check("t5_done",  last(cb_f, 14), 32'b0_000000000001_0);

        // Reset at bit 4 with hold full: frame aborted, held word dropped.
        tick();
        din_a = 8'hF0; msb_a = 1'b1; lv_a = 1'b1;
        tick();
        din_a = 8'h0F;
        tick(); lv_a = 1'b0;
        repeat (3) tick();
        check("t6_hold_full", lr_a, 1'b0);
        check("t6_bit4_valid", sv_a, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_out",   so_a, 1'b0);
        check("t6_rst_valid", sv_a, 1'b0);
        check("t6_rst_done",  fd_a, 1'b0);
        check("t6_rst_ready", lr_a, 1'b1);
        tick();
        reset = 1'b0;
        settle(20);
        check("t6_no_valid", last(ca_v, 20), 32'd0);
        check("t6_no_done",  last(ca_f, 20), 32'd0);

        // Reset released between edges; 1E LSB-first accepted on the next edge.
        tick();
        reset = 1'b1;
        #2 reset = 1'b0;
        din_a = 8'h1E; msb_a = 1'b0; lv_a = 1'b1;
        @(posedge clock); #2 lv_a = 1'b0;
        settle(9);
        check("t7_out",   last(ca_o, 10), 32'b0_01111000_0);
        check("t7_valid", last(ca_v, 10), 32'b0_11111111_0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
